sc_output_decoder: RTL and testbench

SC_OUTPUT_DECODER -- requirements
Module: sc_output_decoder

---
 rtl/sc_pkg.sv | 21 ++
 rtl/sc_ones_counter.sv | 32 +++
 rtl/sc_output_decoder.sv | 134 +++++++++++++
 tb/tb_sc_output_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================
// sc_pkg : shared FSM state type and index-width helper
// Rev 1.0
// ============================================================
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } sc_state_e;

  // Never returns 0 so that a single-channel build still has a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_ones_counter.sv
`default_nettype none
// ============================================================
// sc_ones_counter : per-channel ones counter, W+1 bits wide
// Rev 1.0
// ============================================================
module sc_ones_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic         bit_in,
  output logic [W:0]   count
);

  logic [W:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en && bit_in) begin
      count_q <= count_q + (W+1)'(1);
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/sc_output_decoder.sv
`default_nettype none
// ============================================================
// sc_output_decoder : counts stochastic ones per channel over a
// 2^W-sample window, then scans for the argmax. Rev 1.0
// ============================================================
module sc_output_decoder
  import sc_pkg::*;
#(
  parameter int N = 10,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N-1:0]           din,
  input  logic                   din_valid,
  output logic                   busy,
  output logic [N*(W+1)-1:0]     counts,
  output logic [idx_w(N)-1:0]    argmax,
  output logic [W:0]             max_count,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int c_iw = idx_w(N);
  localparam int c_cw = W + 1;
  localparam logic [c_cw-1:0] c_last_sample = c_cw'((1 << W) - 1);
  localparam logic [c_iw-1:0] c_last_idx    = c_iw'(N - 1);

  sc_state_e         state_q, state_d;
  logic [c_cw-1:0]   sample_cnt_q, sample_cnt_d;
  logic [c_iw-1:0]   scan_idx_q, scan_idx_d;
  logic [c_iw-1:0]   argmax_q, argmax_d;
  logic [c_cw-1:0]   max_q, max_d;
  logic              w_clear, w_en;
  logic [c_cw-1:0]   w_cnt [N];
  logic [c_cw-1:0]   w_cur;

  for (genvar i = 0; i < N; i++) begin : g_ch
    sc_ones_counter #(.W(W)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (w_clear),
      .en     (w_en),
      .bit_in (din[i]),
      .count  (w_cnt[i])
    );
    assign counts[i*c_cw +: c_cw] = w_cnt[i];
  end

  assign w_cur = w_cnt[scan_idx_q];

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    scan_idx_d   = scan_idx_q;
    argmax_d     = argmax_q;
    max_d        = max_q;
    w_clear      = 1'b0;
    w_en         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_clear      = 1'b1;
          sample_cnt_d = '0;
          argmax_d     = '0;
          max_d        = '0;
          state_d      = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (din_valid) begin
          w_en         = 1'b1;
          sample_cnt_d = sample_cnt_q + c_cw'(1);
          if (sample_cnt_q == c_last_sample) begin
            state_d    = ST_SCAN;
            scan_idx_d = '0;
            argmax_d   = '0;
            max_d      = '0;
          end
        end
      end
      ST_SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if (w_cur > max_q) begin
          max_d    = w_cur;
          argmax_d = scan_idx_q;
        end
        if (scan_idx_q == c_last_idx) begin
          state_d = ST_DONE;
        end else begin
          scan_idx_d = scan_idx_q + c_iw'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (start) begin
            w_clear      = 1'b1;
            sample_cnt_d = '0;
            argmax_d     = '0;
            max_d        = '0;
            state_d      = ST_ACCUM;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      scan_idx_q   <= '0;
      argmax_q     <= '0;
      max_q        <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      scan_idx_q   <= scan_idx_d;
      argmax_q     <= argmax_d;
      max_q        <= max_d;
    end
  end

  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_SCAN);
  assign out_valid = (state_q == ST_DONE);
  assign argmax    = argmax_q;
  assign max_count = max_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_output_decoder.sv
`default_nettype none
// ============================================================
// tb_sc_output_decoder : directed vectors, scoreboard-checked
// Rev 1.0
// ============================================================
module tb_sc_output_decoder;

  localparam int N  = 10;
  localparam int W  = 4;
  localparam int CW = W + 1;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              reset, start, din_valid, out_ready;
  logic [N-1:0]      din;
  logic              busy, out_valid;
  logic [N*CW-1:0]   counts;
  logic [IW-1:0]     argmax;
  logic [CW-1:0]     max_count;

  typedef struct packed {
    logic [N*CW-1:0] counts;
    logic [IW-1:0]   am;
    logic [CW-1:0]   mx;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  sc_output_decoder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .busy      (busy),
    .counts    (counts),
    .argmax    (argmax),
    .max_count (max_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [N*CW-1:0] ch(input int c, input int v);
    logic [N*CW-1:0] r;
    r = '0;
    r[c*CW +: CW] = CW'(v);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [N*CW-1:0] c, input int a, input int m);
    exp_t e;
    e.counts = c;
    e.am     = IW'(a);
    e.mx     = CW'(m);
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [N-1:0] d);
    din       = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = '0;
  endtask

  task automatic start_win;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges from the final accepted sample until out_valid is seen.
  task automatic wait_out(input string name);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    chk(name, 64'(k), 64'(N));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_counts"},    64'(counts),    64'(0));
    chk({tag, "_argmax"},    64'(argmax),    64'(0));
    chk({tag, "_max"},       64'(max_count), 64'(0));
  endtask

  // Monitor: pops one expected result per completed output handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got an output with no expected entry (argmax %0d)", argmax);
        end else begin
          e = sb.pop_front();
          chk("sb_counts", 64'(counts),    64'(e.counts));
          chk("sb_argmax", 64'(argmax),    64'(e.am));
          chk("sb_max",    64'(max_count), 64'(e.mx));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [N-1:0] d;
    reset = 1'b0; start = 1'b0; din = '0; din_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk_zero("rst");
    reset = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 64'(0));

    // Single hot channel
    push(ch(3, 16), 3, 16);
    start_win();
    chk("t1_busy", 64'(busy), 64'(1));
    for (int j = 0; j < 16; j++) feed(N'(1) << 3);
    wait_out("t1_latency");
    tick();
    chk("t1_drop_valid", 64'(out_valid), 64'(0));
    chk("t1_idle_busy",  64'(busy),      64'(0));

    // Tie between channels 2 and 7 resolves to the lower index
    push(ch(2, 12) | ch(5, 11) | ch(7, 12), 2, 12);
    start_win();
    for (int j = 0; j < 16; j++) begin
      d = '0;
      d[2] = (j < 12);
      d[5] = (j < 11);
      d[7] = (j >= 4);
      feed(d);
    end
    wait_out("t2_latency");
    tick();

    // Alternating din_valid; junk on invalid cycles must be ignored
    push(ch(0, 16), 0, 16);
    start_win();
    for (int j = 0; j < 32; j++) begin
      if (j % 2 == 1) begin
        feed(N'(1));
      end else begin
        din = '1; din_valid = 1'b0;
        tick();
        din = '0;
      end
    end
    wait_out("t3_latency");
    tick();

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    push(ch(4, 8) | ch(9, 16), 9, 16);
    start_win();
    for (int j = 0; j < 16; j++) feed((N'(1) << 9) | ((j % 2 == 1) ? (N'(1) << 4) : N'(0)));
    wait_out("t4_latency");
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("t4_hold_valid", 64'(out_valid), 64'(1));
      chk("t4_hold_data", 64'({counts, argmax, max_count}),
          64'({ch(4, 8) | ch(9, 16), IW'(9), CW'(16)}));
    end
    out_ready = 1'b1;
    tick();
    chk("t4_drop_valid", 64'(out_valid), 64'(0));
    chk("t4_idle_busy",  64'(busy),      64'(0));

    // Reset mid-accumulation, then a clean window
    start_win();
    for (int j = 0; j < 5; j++) feed('1);
    reset = 1'b0;
    tick();
    chk_zero("t5_rst");
    reset = 1'b1;
    tick();
    push(ch(1, 16), 1, 16);
    start_win();
    for (int j = 0; j < 16; j++) feed(N'(1) << 1);
    wait_out("t5_latency");
    tick();

    // start mid-ACCUM ignored; start+out_ready in DONE chains windows
    out_ready = 1'b0;
    push(ch(6, 16), 6, 16);
    start_win();
    for (int j = 0; j < 8; j++) feed(N'(1) << 6);
    start = 1'b1;
    feed(N'(1) << 6);
    start = 1'b0;
    chk("t6_busy_mid", 64'(busy), 64'(1));
    for (int j = 0; j < 7; j++) feed(N'(1) << 6);
    wait_out("t6_latency");
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_b2b_busy",   64'(busy),      64'(1));
    chk("t6_b2b_valid",  64'(out_valid), 64'(0));
    chk("t6_b2b_counts", 64'(counts),    64'(0));
    push(ch(8, 16), 8, 16);
    for (int j = 0; j < 16; j++) feed(N'(1) << 8);
    wait_out("t6b_latency");
    tick();
    tick();

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
